// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine with architectural HI/LO registers (MULTU/MULT/DIVU/DIV, MTHI/MTLO).
// Optional macro MULDIV_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier is zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int               CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DIV0_HI    = WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {remainder, quotient}
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, or divisor
    logic [1:0]         op_q, op_d;
    logic               sx_q, sx_d;
    logic               sy_q, sy_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   x_abs, y_abs;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               calc_last;

    assign x_abs    = (op[0] && x[WIDTH-1]) ? -x : x;
    assign y_abs    = (op[0] && y[WIDTH-1]) ? -y : y;
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mplier_q};
    assign prod_fix = (sx_q ^ sy_q) ? -acc_q : acc_q;
    assign quot_fix = (sx_q ^ sy_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sx_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_TERM_EN
    assign calc_last = (count_q == LAST_COUNT) || (!op_q[1] && (mplier_q[WIDTH-1:1] == '0));
`else
    assign calc_last = (count_q == LAST_COUNT);
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        op_d       = op_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d    = CALC;
                    count_d    = '0;
                    op_d       = op;
                    sx_d       = op[0] & x[WIDTH-1];
                    sy_d       = op[0] & y[WIDTH-1];
                    mplier_d   = y_abs;
                    div_zero_d = 1'b0;
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, x_abs};
                        mcand_d = '0;
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, x_abs};
                    end
                end
            end
            CALC: begin
                count_d = count_q + 1'b1;
                if (!op_q[1]) begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end else if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
                if (calc_last) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (mplier_q == '0) begin
                    hi_d       = DIV0_HI;
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush cancels everything, including a same-cycle start or HI/LO write.
        if (flush) begin
            state_d    = IDLE;
            count_d    = '0;
            done_d     = 1'b0;
            hi_d       = hi_q;
            lo_d       = lo_q;
            div_zero_d = div_zero_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            op_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            op_q       <= op_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule
